// File: rtl/volume_dispenser.sv
// Digit-entry volume dispenser: builds a decimal amount from switch presses,
// then opens the valve for amount*CYCLES_PER_ML cycles with pause/resume/cancel.
module volume_dispenser #(
  parameter int CLOCK_PERIOD_NS = 20,
  parameter int NS_PER_ML       = 1000000,
  parameter int MAX_DIGITS      = 4,
  parameter int SWITCH_COUNT    = 10,
  localparam int CYCLES_PER_ML  = NS_PER_ML / CLOCK_PERIOD_NS,
  localparam int AMOUNT_WIDTH   = $clog2(10**MAX_DIGITS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [SWITCH_COUNT-1:0] switches,
  input  logic                    button_add,
  input  logic                    button_ok,
  input  logic                    button_cancel,
  output logic [1:0]              current_state,
  output logic                    valve_open,
  output logic [AMOUNT_WIDTH-1:0] total_amount_in_ml,
  output logic [AMOUNT_WIDTH-1:0] remaining_ml,
  output logic                    done
);

  localparam int TICK_W = (CYCLES_PER_ML > 1) ? $clog2(CYCLES_PER_ML) : 1;
  localparam int CNT_W  = $clog2(MAX_DIGITS + 1);

  localparam logic [1:0] ST_READ     = 2'd0;
  localparam logic [1:0] ST_DISPENSE = 2'd1;
  localparam logic [1:0] ST_PAUSED   = 2'd2;

  if (CYCLES_PER_ML < 1 || CYCLES_PER_ML * CLOCK_PERIOD_NS != NS_PER_ML) begin : g_bad_rate
    $error("NS_PER_ML must be a non-zero exact multiple of CLOCK_PERIOD_NS");
  end
  if (SWITCH_COUNT > 10 || SWITCH_COUNT < 1) begin : g_bad_switches
    $error("SWITCH_COUNT must be in 1..10");
  end

  logic [1:0]              r_state;
  logic                    r_valve;
  logic                    r_done;
  logic [AMOUNT_WIDTH-1:0] r_amount;
  logic [AMOUNT_WIDTH-1:0] r_remaining;
  logic [CNT_W-1:0]        r_count;
  logic [TICK_W-1:0]       r_tick;

  logic [3:0]              w_digit;
  logic                    w_any_switch;
  logic                    w_accept_digit;
  logic                    w_wrap;

  // Lowest-index set switch wins, so scan from the top down.
  always_comb begin
    w_digit = 4'd0;
    for (int i = SWITCH_COUNT - 1; i >= 0; i--) begin
      if (switches[i]) w_digit = 4'(i);
    end
  end

  assign w_any_switch   = |switches;
  assign w_accept_digit = w_any_switch && (r_count < CNT_W'(MAX_DIGITS)) &&
                          !((r_amount == '0) && (w_digit == 4'd0));
  assign w_wrap         = (r_tick == TICK_W'(CYCLES_PER_ML - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_READ;
      r_valve     <= 1'b0;
      r_done      <= 1'b0;
      r_amount    <= '0;
      r_remaining <= '0;
      r_count     <= '0;
      r_tick      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_READ: begin
          if (button_cancel) begin
            r_amount <= '0;
            r_count  <= '0;
          end else if (button_ok) begin
            if (r_amount != '0) begin
              r_state     <= ST_DISPENSE;
              r_valve     <= 1'b1;
              r_remaining <= r_amount;
              r_tick      <= '0;
            end
          end else if (button_add && w_accept_digit) begin
            r_amount <= AMOUNT_WIDTH'(r_amount * AMOUNT_WIDTH'(10) + AMOUNT_WIDTH'(w_digit));
            r_count  <= r_count + CNT_W'(1);
          end
        end
        ST_DISPENSE: begin
          if (button_cancel) begin
            r_state     <= ST_READ;
            r_valve     <= 1'b0;
            r_amount    <= '0;
            r_remaining <= '0;
            r_count     <= '0;
            r_tick      <= '0;
          end else if (w_wrap && (r_remaining == AMOUNT_WIDTH'(1))) begin
            // Completion takes precedence over a coincident pause request.
            r_state     <= ST_READ;
            r_valve     <= 1'b0;
            r_done      <= 1'b1;
            r_amount    <= '0;
            r_remaining <= '0;
            r_count     <= '0;
            r_tick      <= '0;
          end else begin
            r_tick <= w_wrap ? '0 : r_tick + TICK_W'(1);
            if (w_wrap) r_remaining <= r_remaining - AMOUNT_WIDTH'(1);
            if (button_ok) begin
              r_state <= ST_PAUSED;
              r_valve <= 1'b0;
            end
          end
        end
        ST_PAUSED: begin
          if (button_cancel) begin
            r_state     <= ST_READ;
            r_amount    <= '0;
            r_remaining <= '0;
            r_count     <= '0;
            r_tick      <= '0;
          end else if (button_ok) begin
            r_state <= ST_DISPENSE;
            r_valve <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_READ;
          r_valve <= 1'b0;
        end
      endcase
    end
  end

  assign current_state      = r_state;
  assign valve_open         = r_valve;
  assign total_amount_in_ml = r_amount;
  assign remaining_ml       = r_remaining;
  assign done               = r_done;

endmodule

// File: tb/tb_volume_dispenser.sv
// Directed bench for volume_dispenser: table of single-cycle entry vectors,
// then hand-written dispense, pause, cancel, reset and full-scale sequences.
module tb_volume_dispenser;

  localparam int AW = 14;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [9:0]    switches = '0;
  logic          button_add = 1'b0;
  logic          button_ok = 1'b0;
  logic          button_cancel = 1'b0;
  logic [1:0]    current_state;
  logic          valve_open;
  logic [AW-1:0] total_amount_in_ml;
  logic [AW-1:0] remaining_ml;
  logic          done;

  int n_checks = 0;
  int n_errors = 0;

  volume_dispenser #(
    .CLOCK_PERIOD_NS(20),
    .NS_PER_ML(100),
    .MAX_DIGITS(4),
    .SWITCH_COUNT(10)
  ) dut (
    .clock(clock),
    .reset(reset),
    .switches(switches),
    .button_add(button_add),
    .button_ok(button_ok),
    .button_cancel(button_cancel),
    .current_state(current_state),
    .valve_open(valve_open),
    .total_amount_in_ml(total_amount_in_ml),
    .remaining_ml(remaining_ml),
    .done(done)
  );

  always #10 clock = ~clock;

  typedef struct {
    logic [9:0] sw;
    logic       add;
    logic       ok;
    logic       cancel;
    int         exp_state;
    int         exp_total;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic press_add(input int d);
    switches = 10'(1 << d);
    button_add = 1'b1;
    step();
    button_add = 1'b0;
    switches = '0;
  endtask

  task automatic press_ok();
    button_ok = 1'b1;
    step();
    button_ok = 1'b0;
  endtask

  task automatic press_cancel();
    button_cancel = 1'b1;
    step();
    button_cancel = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_state"}, int'(current_state), 0);
    check({tag, "_valve"}, int'(valve_open), 0);
    check({tag, "_total"}, int'(total_amount_in_ml), 0);
    check({tag, "_remaining"}, int'(remaining_ml), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    int valve_cnt;
    int done_cnt;
    int exp_rem;
    int viol;
    int post;
    int done_seen;

    vecs[0]  = '{10'h000, 1'b1, 1'b0, 1'b0, 0, 0};
    vecs[1]  = '{10'h001, 1'b1, 1'b0, 1'b0, 0, 0};
    vecs[2]  = '{10'h001, 1'b1, 1'b0, 1'b0, 0, 0};
    vecs[3]  = '{10'h002, 1'b1, 1'b0, 1'b0, 0, 1};
    vecs[4]  = '{10'h004, 1'b1, 1'b0, 1'b0, 0, 12};
    vecs[5]  = '{10'h008, 1'b1, 1'b0, 1'b0, 0, 123};
    vecs[6]  = '{10'h010, 1'b1, 1'b0, 1'b0, 0, 1234};
    vecs[7]  = '{10'h020, 1'b1, 1'b0, 1'b0, 0, 1234};
    vecs[8]  = '{10'h000, 1'b1, 1'b0, 1'b0, 0, 1234};
    vecs[9]  = '{10'h088, 1'b1, 1'b0, 1'b0, 0, 1234};
    vecs[10] = '{10'h000, 1'b0, 1'b1, 1'b1, 0, 0};
    vecs[11] = '{10'h000, 1'b0, 1'b1, 1'b0, 0, 0};
    vecs[12] = '{10'h084, 1'b1, 1'b0, 1'b0, 0, 2};
    vecs[13] = '{10'h001, 1'b1, 1'b0, 1'b0, 0, 20};
    vecs[14] = '{10'h000, 1'b0, 1'b0, 1'b1, 0, 0};
    vecs[15] = '{10'h200, 1'b1, 1'b0, 1'b0, 0, 9};
    vecs[16] = '{10'h010, 1'b1, 1'b0, 1'b1, 0, 0};
    vecs[17] = '{10'h001, 1'b1, 1'b0, 1'b0, 0, 0};
    vecs[18] = '{10'h002, 1'b1, 1'b0, 1'b0, 0, 1};
    vecs[19] = '{10'h000, 1'b0, 1'b0, 1'b1, 0, 0};

    // Reset
    reset = 1'b1;
    step();
    step();
    check_idle("reset");
    reset = 1'b0;

    // Digit entry table
    for (int i = 0; i < 20; i++) begin
      switches      = vecs[i].sw;
      button_add    = vecs[i].add;
      button_ok     = vecs[i].ok;
      button_cancel = vecs[i].cancel;
      step();
      switches      = '0;
      button_add    = 1'b0;
      button_ok     = 1'b0;
      button_cancel = 1'b0;
      check($sformatf("vec%0d_state", i), int'(current_state), vecs[i].exp_state);
      check($sformatf("vec%0d_total", i), int'(total_amount_in_ml), vecs[i].exp_total);
      check($sformatf("vec%0d_valve", i), int'(valve_open), 0);
    end

    // Full dispense of 3 ml
    press_add(3);
    press_ok();
    valve_cnt = 0;
    done_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      exp_rem = (k <= 15) ? 3 - (k - 1) / 5 : 0;
      check($sformatf("full_rem_k%0d", k), int'(remaining_ml), exp_rem);
      if (valve_open) valve_cnt++;
      if (done) begin
        done_cnt++;
        check("full_done_cycle", k, 16);
        check("full_done_state", int'(current_state), 0);
      end
      step();
    end
    check("full_valve_cycles", valve_cnt, 15);
    check("full_done_count", done_cnt, 1);
    check("full_end_state", int'(current_state), 0);
    check("full_end_total", int'(total_amount_in_ml), 0);

    // Pause / resume with 2 ml
    press_add(2);
    press_ok();
    valve_cnt = 0;
    for (int i = 0; i < 20 && valve_cnt < 7; i++) begin
      if (valve_open) valve_cnt++;
      if (valve_cnt < 7) step();
    end
    check("pause_pre_valve", valve_cnt, 7);
    press_ok();
    check("pause_state", int'(current_state), 2);
    check("pause_valve", int'(valve_open), 0);
    check("pause_rem", int'(remaining_ml), 1);
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (remaining_ml != AW'(1) || valve_open || current_state != 2'd2) viol++;
    end
    check("pause_frozen_violations", viol, 0);
    press_ok();
    check("resume_state", int'(current_state), 1);
    check("resume_valve", int'(valve_open), 1);
    check("resume_rem", int'(remaining_ml), 1);
    post = 0;
    for (int i = 0; i < 20; i++) begin
      if (remaining_ml == '0) break;
      if (valve_open) post++;
      step();
    end
    check("resume_valve_cycles", post, 3);
    check("pause_total_valve", valve_cnt + post, 10);
    check("resume_done", int'(done), 1);
    check("resume_end_state", int'(current_state), 0);

    // Ok coinciding with the final wrap: completion wins
    press_add(1);
    press_ok();
    for (int i = 0; i < 4; i++) step();
    press_ok();
    check("wrapok_state", int'(current_state), 0);
    check("wrapok_done", int'(done), 1);
    check("wrapok_rem", int'(remaining_ml), 0);
    check("wrapok_valve", int'(valve_open), 0);
    step();

    // Cancel mid-dispense
    press_add(5);
    press_ok();
    done_seen = 0;
    for (int i = 0; i < 7; i++) begin
      if (done) done_seen++;
      step();
    end
    press_cancel();
    check_idle("cancel");
    for (int i = 0; i < 10; i++) begin
      if (done) done_seen++;
      step();
    end
    check("cancel_done_seen", done_seen, 0);

    // Reset while paused
    press_add(4);
    press_ok();
    for (int i = 0; i < 3; i++) step();
    press_ok();
    check("rstpause_state", int'(current_state), 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle("rstpause");
    press_add(5);
    check("rstpause_reentry", int'(total_amount_in_ml), 5);
    press_cancel();

    // Full-scale 9999 ml
    for (int i = 0; i < 5; i++) press_add(9);
    check("max_total", int'(total_amount_in_ml), 9999);
    press_ok();
    valve_cnt = 0;
    for (int i = 0; i < 60000; i++) begin
      if (remaining_ml == '0) break;
      if (valve_open) valve_cnt++;
      step();
    end
    check("max_valve_cycles", valve_cnt, 49995);
    check("max_rem", int'(remaining_ml), 0);
    check("max_done", int'(done), 1);
    check("max_state", int'(current_state), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/volume_dispenser.md
# volume_dispenser

Parametrised successor to the single-channel water dispenser controller. It takes digit entry from a switch bank, then meters the entered volume in millilitres by opening a valve for a cycle count derived from the clock period and flow rate. Dispensing can be paused and resumed, and the block reports remaining volume live. It sits between the button edge-detector blocks and the valve driver / seven-segment display logic.

## Interface
Parameters:
- CLOCK_PERIOD_NS, default 20: clock period in ns.
- NS_PER_ML, default 1000000: ns of valve-open time per ml.
- MAX_DIGITS, default 4: maximum significant digits accepted.
- SWITCH_COUNT, default 10: switches; switch i encodes digit i; must be ≤ 10.
- Derived CYCLES_PER_ML = NS_PER_ML / CLOCK_PERIOD_NS: elaboration error unless it is ≥ 1 and exact.
- Derived AMOUNT_WIDTH = $clog2(10**MAX_DIGITS).

Ports (one clock; reset is synchronous and active-high):
- clock, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- switches, input, SWITCH_COUNT: digit selector; the lowest-index set bit wins.
- button_add, input, 1: single-cycle press pulse; appends a digit.
- button_ok, input, 1: single-cycle pulse; start / pause / resume.
- button_cancel, input, 1: single-cycle pulse; clear or abort.
- current_state, output, 2: 0 = READING_INPUT, 1 = DISPENSING, 2 = PAUSED.
- valve_open, output, 1: high only in DISPENSING.
- total_amount_in_ml, output, AMOUNT_WIDTH: entered volume.
- remaining_ml, output, AMOUNT_WIDTH: volume still to dispense.
- done, output, 1: one-cycle pulse on normal completion.

## Operation
- Button pulse priority in one cycle: cancel > ok > add.
- Add rules (READING_INPUT only):
  - If no switch is set, the press is ignored.
  - Let d be the lowest set switch index. If amount == 0 and d == 0, nothing changes; leading zeros are not counted.
  - Otherwise amount ← amount*10 + d and digit_count increments.
  - Presses with digit_count == MAX_DIGITS are ignored, so amount ≤ 10**MAX_DIGITS − 1.
- Cancel in READING_INPUT clears amount and digit_count.
- Ok in READING_INPUT with amount > 0:
  - Go to DISPENSING, load remaining_ml ← amount, clear tick counter.
  - Ok with amount == 0 is ignored.
- DISPENSING:
  - Tick counter counts 0..CYCLES_PER_ML−1. On wrap, remaining_ml decrements.
  - When a decrement takes remaining_ml from 1 to 0: pulse done, go to READING_INPUT, clear amount and digit_count.
- Ok in DISPENSING goes to PAUSED. In PAUSED, tick counter and remaining_ml are frozen and valve_open = 0.
- Ok in PAUSED returns to DISPENSING. The tick counter resumes from its frozen value; no restart.
- Cancel in DISPENSING or PAUSED: go to READING_INPUT, clear amount, remaining_ml and digit_count; no done pulse.
- Add is ignored in DISPENSING and PAUSED.
- Wrap coinciding with ok in DISPENSING: the decrement happens, then PAUSED. If that decrement reaches 0, completion wins over pause.
- Wrap coinciding with cancel: cancel wins; no done pulse.

## Timing
- All outputs are registered.
- Reset values: current_state = 0, valve_open = 0, total_amount_in_ml = 0, remaining_ml = 0, done = 0. Internal digit_count and tick counter = 0.
- Reset mid-dispense aborts on the next edge with all outputs at reset values.
- Add pulse at edge n: total_amount_in_ml updates at n+1.
- Ok pulse at edge n: current_state = 1, valve_open = 1 and remaining_ml = amount at n+1.
- Valve-open cycles total exactly amount*CYCLES_PER_ML, excluding paused cycles.
- done is high for exactly the one cycle in which current_state first reads 0 after completion.
- Pause and resume each take effect one cycle after the ok pulse.

## Test plan
Bench parameters: CLOCK_PERIOD_NS = 20, NS_PER_ML = 100, so CYCLES_PER_ML = 5; MAX_DIGITS = 4.
- Digit entry:
  - Stimulus: adds with switch indices 0, 0, 1, 2, 3, 4, 5.
  - Required: total_amount_in_ml = 1234. Leading zeros are ignored and the 5th significant digit is ignored.
  - Also: an add with switches = 0 leaves the amount unchanged.
- Full dispense:
  - Stimulus: amount 3, then ok.
  - Required: valve_open high for exactly 15 cycles. remaining_ml steps 3→2→1→0 every 5 cycles. done pulses once. State returns to 0 and total_amount_in_ml = 0.
- Pause/resume:
  - Stimulus: amount 2, ok, pause after 7 valve cycles (remaining_ml = 1, tick = 2), hold 20 cycles, ok.
  - Required: remaining_ml and valve_open frozen during the pause. The final decrement happens 3 cycles after resume; total valve-open cycles = 10.
- Cancel:
  - Stimulus: cancel mid-dispense.
  - Required: next cycle state = 0, valve_open = 0, remaining_ml = 0, done never asserted.
  - Also: cancel plus ok in the same cycle in READING_INPUT clears the amount and does not start dispensing.
- Boundaries:
  - Ok with amount 0: no state change.
  - Synchronous reset asserted in PAUSED: all outputs at reset values after one edge.
  - Amount 9999 (counted): remaining_ml reaches 0 after exactly 49995 valve-open cycles.
